// File: rtl/mem_burst_pkg.sv
// Shared types and default sizing for the memory burst writer.
package mem_burst_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NWORDS = 16;
   localparam int DEF_ADDR_W = 16;

   // Burst sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/mem_burst_wordsel.sv
// Combinational selector: returns word idx_i from a packed buffer whose
// word 0 occupies the most-significant DATA_W bits.
module mem_burst_wordsel
   import mem_burst_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NWORDS = DEF_NWORDS,
   parameter int IDX_W  = $clog2(NWORDS + 1)
) (
   input  logic [DATA_W*NWORDS-1:0] buff_i,
   input  logic [IDX_W-1:0]         idx_i,
   output logic [DATA_W-1:0]        word_o
);

   // Mux the addressed word out of the buffer; out-of-range indices give zero
   always_comb begin
      word_o = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (idx_i == IDX_W'(k)) begin
            word_o = buff_i[(NWORDS-1-k)*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/mem_burst_writer.sv
// Burst writer: copies up to NWORDS words from a captured buffer to memory,
// one SETUP/STROBE pair per word, then pulses Done.
//
// Build option: define MEM_BURST_WAIT_EN to let MemReady stretch STROBE;
// without it every STROBE lasts one cycle and MemReady is ignored.
//
//   state  | meaning
//   IDLE   | waiting for Start; Busy low
//   SETUP  | Addr/DataOut of current word presented, WR low
//   STROBE | WR high, Addr/DataOut held until the write is accepted
//   DONE   | one-cycle Done pulse, then back to IDLE
module mem_burst_writer
   import mem_burst_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NWORDS = DEF_NWORDS,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = $clog2(NWORDS + 1)
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Start,
   input  logic                     Abort,
   input  logic [DATA_W*NWORDS-1:0] DataBuff,
   input  logic [ADDR_W-1:0]        AddrIn,
   input  logic [ADDR_W-1:0]        Stride,
   input  logic [LEN_W-1:0]         Len,
   input  logic                     MemReady,
   output logic [ADDR_W-1:0]        Addr,
   output logic [DATA_W-1:0]        DataOut,
   output logic                     WR,
   output logic                     Busy,
   output logic                     Done
);

   state_e                     state_q, state_d;
   logic [DATA_W*NWORDS-1:0]   buff_q, buff_d;
   logic [ADDR_W-1:0]          stride_q, stride_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [LEN_W-1:0]           idx_q, idx_d;
   logic [DATA_W-1:0]          data_q, data_d;
   logic                       wr_q, wr_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic [LEN_W-1:0]           len_eff;
   logic                       accept;
   logic                       last_word;
   logic                       start_ok;
   logic                       advance;
   logic [DATA_W*NWORDS-1:0]   sel_buff;
   logic [LEN_W-1:0]           sel_idx;
   logic [DATA_W-1:0]          sel_word;

`ifdef MEM_BURST_WAIT_EN
   assign accept = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign accept           = 1'b1;
`endif

   assign len_eff   = (Len > LEN_W'(NWORDS)) ? LEN_W'(NWORDS) : Len;
   assign last_word = ((idx_q + LEN_W'(1)) == len_q);
   assign start_ok  = (state_q == IDLE) && Start && !Abort;
   assign advance   = (state_q == STROBE) && !Abort && accept && !last_word;

   // The selector looks at the word that will be presented next cycle:
   // word 0 of the incoming buffer on a start, the following word on advance.
   assign sel_buff = start_ok ? DataBuff : buff_q;
   assign sel_idx  = start_ok ? '0 : (advance ? idx_q + LEN_W'(1) : idx_q);

   mem_burst_wordsel #(
      .DATA_W (DATA_W),
      .NWORDS (NWORDS),
      .IDX_W  (LEN_W)
   ) u_wordsel (
      .buff_i (sel_buff),
      .idx_i  (sel_idx),
      .word_o (sel_word)
   );

   // Next-state and next-output computation for the burst sequencer
   always_comb begin
      state_d  = state_q;
      buff_d   = buff_q;
      stride_d = stride_q;
      addr_d   = addr_q;
      len_d    = len_q;
      idx_d    = idx_q;
      data_d   = data_q;
      wr_d     = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_ok) begin
               buff_d   = DataBuff;
               stride_d = Stride;
               len_d    = len_eff;
               idx_d    = '0;
               addr_d   = AddrIn;
               data_d   = sel_word;
               busy_d   = 1'b1;
               if (len_eff == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = SETUP;
               end
            end
         end

         SETUP: begin
            if (Abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = STROBE;
               wr_d    = 1'b1;
            end
         end

         STROBE: begin
            if (Abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (!accept) begin
               wr_d = 1'b1;
            end else if (last_word) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d = SETUP;
               idx_d   = sel_idx;
               addr_d  = addr_q + stride_q;
               data_d  = sel_word;
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         buff_q   <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         buff_q   <= buff_d;
         stride_q <= stride_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign Addr    = addr_q;
   assign DataOut = data_q;
   assign WR      = wr_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_mem_burst_writer.sv
// Scoreboard bench for mem_burst_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted write.
module tb_mem_burst_writer;

   localparam int DATA_W = 16;
   localparam int NWORDS = 16;
   localparam int ADDR_W = 16;
   localparam int LEN_W  = 5;

   logic                     Clk;
   logic                     Rst;
   logic                     Start;
   logic                     Abort;
   logic [DATA_W*NWORDS-1:0] DataBuff;
   logic [ADDR_W-1:0]        AddrIn;
   logic [ADDR_W-1:0]        Stride;
   logic [LEN_W-1:0]         Len;
   logic                     MemReady;
   logic [ADDR_W-1:0]        Addr;
   logic [DATA_W-1:0]        DataOut;
   logic                     WR;
   logic                     Busy;
   logic                     Done;

   mem_burst_writer #(
      .DATA_W (DATA_W),
      .NWORDS (NWORDS),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Start    (Start),
      .Abort    (Abort),
      .DataBuff (DataBuff),
      .AddrIn   (AddrIn),
      .Stride   (Stride),
      .Len      (Len),
      .MemReady (MemReady),
      .Addr     (Addr),
      .DataOut  (DataOut),
      .WR       (WR),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

`ifdef MEM_BURST_WAIT_EN
   localparam bit WAIT_MODE = 1'b1;
`else
   localparam bit WAIT_MODE = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a write is taken at the edge ending a cycle with WR high,
   // no Abort, no reset and (in wait builds) MemReady high.
   logic              pend;
   logic [ADDR_W-1:0] pend_a;
   logic [DATA_W-1:0] pend_d;
   logic              acc_m;
   wr_t               got;
   initial pend = 1'b0;

   always @(negedge Clk) begin
      if (Rst) begin
         pend = 1'b0;
      end else begin
         acc_m = WR && !Abort && (WAIT_MODE ? MemReady : 1'b1);
         if (pend && WR) begin
            chk("hold_addr", Addr, pend_a);
            chk("hold_data", DataOut, pend_d);
         end
         if (acc_m) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", Addr, DataOut);
            end else begin
               got = exp_q.pop_front();
               chk("write_addr", Addr, got.a);
               chk("write_data", DataOut, got.d);
            end
         end
         pend   = WR && !acc_m;
         pend_a = Addr;
         pend_d = DataOut;
         if (Done) begin
            done_cnt++;
            chk("done_wr_low", WR, 0);
         end
      end
   end

   // kind: 0 normal, 1 abort in cycle kc, 2 reset in cycle kc.
   // fixed_w1 >= 0 forces the MemReady-low count on word 1 (wait builds).
   task automatic run_burst(input logic [15:0] w[16], input logic [15:0] base,
                            input logic [15:0] stride, input logic [4:0] len,
                            input int kind, input int kc, input int maxwait,
                            input int fixed_w1);
      int  eff, d, s, nexp, st, last, done0;
      int  wt[16];
      int  accc[16];
      bit  rdy[256];
      logic [255:0] bus;
      wr_t e;

      eff = (len > 16) ? 16 : int'(len);
      for (int i = 0; i < 256; i++) rdy[i] = 1'b1;
      s = 0;
      for (int k = 0; k < eff; k++) begin
         wt[k] = WAIT_MODE ? int'($urandom_range(0, maxwait)) : 0;
         if (WAIT_MODE && k == 1 && fixed_w1 >= 0) wt[k] = fixed_w1;
         st = 2*k + 2 + s;
         for (int j = 0; j < wt[k]; j++) rdy[st+j] = 1'b0;
         accc[k] = st + wt[k];
         s += wt[k];
      end
      d = 2*eff + 1 + s;

      nexp = 0;
      for (int k = 0; k < eff; k++)
         if (kind == 0 || accc[k] < kc) nexp++;
      for (int k = 0; k < nexp; k++) begin
         e.a = base + 16'(k) * stride;
         e.d = w[k];
         exp_q.push_back(e);
      end

      bus = '0;
      for (int k = 0; k < 16; k++) bus = {bus[239:0], w[k]};

      done0 = done_cnt;
      last  = (kind != 0) ? kc : d;

      @(posedge Clk); #1;
      DataBuff = bus; AddrIn = base; Stride = stride; Len = len;
      Start = 1'b1; Abort = 1'b0; MemReady = 1'b1;

      for (int c = 1; c <= last; c++) begin
         @(posedge Clk); #1;
         Start    = 1'($urandom);
         DataBuff = {8{$urandom}};
         AddrIn   = 16'($urandom);
         Stride   = 16'($urandom);
         Len      = 5'($urandom);
         MemReady = WAIT_MODE ? rdy[c] : 1'($urandom);
         Abort    = (kind == 1 && c == kc) ? 1'b1 :
                    (kind == 0 && c == d) ? 1'($urandom) : 1'b0;
         if (kind == 2 && c == kc) begin
            #2 Rst = 1'b1;
            #1;
            chk("rst_wr",   WR, 0);
            chk("rst_addr", Addr, 0);
            chk("rst_data", DataOut, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            Start = 1'b0;
            Abort = 1'b0;
            Rst   = 1'b0;
         end else begin
            @(negedge Clk);
            chk("busy", Busy, 1);
            chk("done", Done, (c == d));
         end
      end

      @(posedge Clk); #1;
      Start = 1'b0; Abort = 1'b0;
      @(negedge Clk);
      chk("idle_busy", Busy, 0);
      chk("idle_wr",   WR, 0);
      chk("idle_done", Done, 0);
      repeat (2) @(negedge Clk);
      chk("done_count", done_cnt - done0, (kind == 0) ? 1 : 0);
      chk("writes_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   logic [15:0] wd[16];
   logic [15:0] wr_[16];

   initial begin
      Rst = 1'b1; Start = 1'b0; Abort = 1'b0; DataBuff = '0;
      AddrIn = '0; Stride = '0; Len = '0; MemReady = 1'b1;
      #12;
      chk("reset_addr", Addr, 0);
      chk("reset_data", DataOut, 0);
      chk("reset_wr",   WR, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      @(negedge Clk);
      Rst = 1'b0;

      wd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088,
             16'h0099, 16'h0012, 16'h0023, 16'h0034, 16'h0045, 16'h0056, 16'h0067, 16'h0078};

      run_burst(wd, 16'h0080, 16'd1, 5'd16, 0, 0, 0, -1);
      run_burst(wd, 16'hFFF8, 16'd4, 5'd3,  0, 0, 0, -1);
      run_burst(wd, 16'h1234, 16'd2, 5'd0,  0, 0, 0, -1);
      run_burst(wd, 16'h0100, 16'd1, 5'd20, 0, 0, 0, -1);
      run_burst(wd, 16'h0200, 16'd1, 5'd8,  1, 12, 0, -1);
      run_burst(wd, 16'h0300, 16'd3, 5'd6,  0, 0, 0, -1);
      run_burst(wd, 16'h0400, 16'd1, 5'd6,  2, 6, 0, -1);
      run_burst(wd, 16'h0500, 16'd1, 5'd4,  0, 0, 0, 3);

      // Abort alongside Start in IDLE keeps the block idle
      @(posedge Clk); #1;
      Start = 1'b1; Abort = 1'b1; Len = 5'd4;
      @(posedge Clk); #1;
      Start = 1'b0; Abort = 1'b0;
      @(negedge Clk);
      chk("idle_abort_busy", Busy, 0);
      chk("idle_abort_wr",   WR, 0);

      for (int n = 0; n < 30; n++) begin
         int kind, len, eff, kc;
         for (int k = 0; k < 16; k++) wr_[k] = 16'($urandom);
         len  = int'($urandom_range(0, 20));
         eff  = (len > 16) ? 16 : len;
         kind = (eff == 0) ? 0 : int'($urandom_range(0, 3));
         if (kind == 3) kind = 0;
         kc   = (kind != 0) ? int'($urandom_range(1, 2*eff)) : 0;
         if (WAIT_MODE && kind != 0) kc = int'($urandom_range(1, 2*eff));
         run_burst(wr_, 16'($urandom), 16'($urandom), 5'(len), kind, kc,
                   (kind == 0) ? 2 : 0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_burst_writer.md
MEM_BURST_WRITER -- requirements
Module: mem_burst_writer

Interface
REQ-001 Parameter DATA_W, default 16, width of one memory word.
REQ-002 Parameter NWORDS, default 16, number of words in the source buffer; must be at least 2.
REQ-003 Parameter ADDR_W, default 16, memory address width.
REQ-004 Parameter LEN_W, default $clog2(NWORDS+1), width of Len.
REQ-005 Port Clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 Port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port Start, input, 1 bit: burst request, sampled only in IDLE.
REQ-008 Port Abort, input, 1 bit: terminates the burst in progress.
REQ-009 Port DataBuff, input, DATA_W*NWORDS bits: source words; word 0 = most-significant DATA_W bits.
REQ-010 Port AddrIn, input, ADDR_W bits: base address.
REQ-011 Port Stride, input, ADDR_W bits: address increment per word.
REQ-012 Port Len, input, LEN_W bits: number of words to write.
REQ-013 Port MemReady, input, 1 bit: memory accepts the current write.
REQ-014 Port Addr, output, ADDR_W bits: memory address.
REQ-015 Port DataOut, output, DATA_W bits: memory write data.
REQ-016 Port WR, output, 1 bit: write strobe.
REQ-017 Port Busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port Done, output, 1 bit: one-cycle burst-complete pulse.

Function
REQ-019 FSM states: IDLE, SETUP, STROBE, DONE; all outputs registered.
REQ-020 IDLE with Start=1 and Abort=0 captures DataBuff, AddrIn, Stride and min(Len,NWORDS), then moves to SETUP.
REQ-021 Start with Len=0 performs no write and moves directly to DONE.
REQ-022 SETUP: drive Addr/DataOut of the current word with WR=0 for exactly one cycle, then move to STROBE.
REQ-023 STROBE: WR=1 with Addr and DataOut held; the write is accepted on the edge where MemReady=1.
REQ-024 On acceptance of the last word, move to DONE; otherwise Addr += Stride (mod 2^ADDR_W, wrap silently), advance word index, move to SETUP.
REQ-025 DONE: Done=1 and WR=0 for one cycle, then return to IDLE.
REQ-026 Latency with no wait states: Start sampled at edge 0; word k has WR high in cycle 2k+2; Done high in cycle 2*Len+1.
REQ-027 Start while Busy is ignored; DataBuff, AddrIn, Stride and Len changes while Busy have no effect.
REQ-028 Abort=1 in SETUP or STROBE returns the FSM to IDLE on the next edge, with WR=0 and Done never asserted for that burst.
REQ-029 Abort=1 in IDLE suppresses a simultaneous Start; Abort=1 in DONE has no effect.

Reset
REQ-030 Rst=1 forces IDLE immediately; Addr=0, DataOut=0, WR=0, Busy=0, Done=0; word index and captured registers cleared.
REQ-031 Reset mid-burst abandons the burst, produces no Done, and WR falls asynchronously.

Configuration
REQ-032 Macro MEM_BURST_WAIT_EN defined: MemReady is honoured; STROBE holds indefinitely while MemReady=0.
REQ-033 Macro MEM_BURST_WAIT_EN undefined: MemReady is ignored and every STROBE lasts exactly one cycle; the port still exists.

Structure
REQ-034 A shared package mem_burst_pkg holds the state enum (IDLE, SETUP, STROBE, DONE) and default parameter constants.
REQ-035 One sub-module, mem_burst_wordsel, is natural: a combinational word selector that extracts word k from the captured buffer; the FSM stays in mem_burst_writer.

Verification
REQ-036 Default parameters, DataBuff=256'h0011002200330044005500660077008800990012002300340045005600670078, AddrIn=16'h0080, Stride=1, Len=16, MemReady=1 -> 16 writes at 0x0080..0x008F with data 0x0011, 0x0022, ... 0x0078; Done in cycle 33.
REQ-037 Same buffer, Stride=4, Len=3, AddrIn=16'hFFF8 -> writes to 0xFFF8, 0xFFFC, 0x0000 (wrap) with data 0x0011, 0x0022, 0x0033.
REQ-038 MEM_BURST_WAIT_EN defined, MemReady low for 3 cycles on word 1 -> WR held 4 cycles with Addr/DataOut stable; Done delayed by 3 cycles.
REQ-039 Len=0 -> no WR; Done in cycle 1. Len=20 -> exactly 16 writes.
REQ-040 Abort asserted during STROBE of word 5 -> WR low on the next edge, no Done, Busy=0; a new Start then runs normally.
REQ-041 Rst pulsed during STROBE of word 2 -> WR falls immediately, all outputs zero, no Done.
